mfcc: RTL and testbench

MFCC -- requirements
Module: mfcc

---
 rtl/mfcc.sv | 126 ++++++++++++
 tb/tb_mfcc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mfcc.sv
// Frame autocorrelation engine: ping-pong sample banks feeding one MAC.
// Emits R[k] >>> 6 for k = 0..NUM_COEF-1 plus an energy-based vad flag.
module mfcc #(
  parameter int                 FRAME_LEN  = 64,
  parameter int                 NUM_COEF   = 20,
  parameter logic signed [31:0] VAD_THRESH = 32'sd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic [15:0] x_i,
  input  logic        write,
  output logic [31:0] x_o,
  output logic [4:0]  out_index,
  output logic        dv_out,
  output logic        vad
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic [5:0] LAST  = 6'(FRAME_LEN - 1);
  localparam logic [4:0] KLAST = 5'(NUM_COEF - 1);

  logic unused_sclk;
  assign unused_sclk = sclk;

  logic [15:0] bank [2][64];

  logic [5:0]  wr_ptr;
  logic        wr_bank;
  logic        rd_bank;
  logic [1:0]  state;
  logic [4:0]  k;
  logic [5:0]  n;
  logic [39:0] acc;

  logic [5:0]         n_lag;
  logic signed [15:0] xa;
  logic signed [15:0] xb;
  logic signed [31:0] prod;
  logic [31:0]        coef;
  logic               frame_done;
  logic               start;

  assign n_lag      = n + {1'b0, k};
  assign xa         = $signed(bank[rd_bank][n]);
  assign xb         = $signed(bank[rd_bank][n_lag]);
  assign prod       = xa * xb;
  assign coef       = acc[37:6];
  assign frame_done = write && (wr_ptr == LAST);
  assign start      = frame_done && (state == S_IDLE);

  // Storage only; pointer state keeps stray writes harmless during reset.
  always_ff @(posedge clk) begin
    if (write) begin
      bank[wr_bank][wr_ptr] <= x_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else if (write) begin
      wr_ptr <= wr_ptr + 6'd1;
      if (start) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      n         <= '0;
      acc       <= '0;
      x_o       <= '0;
      out_index <= '0;
      dv_out    <= 1'b0;
      vad       <= 1'b0;
    end else begin
      dv_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_MAC;
            k     <= '0;
            n     <= '0;
            acc   <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + {{8{prod[31]}}, prod};
          if (n == LAST - {1'b0, k}) begin
            state <= S_EMIT;
          end else begin
            n <= n + 6'd1;
          end
        end
        S_EMIT: begin
          x_o       <= coef;
          out_index <= k;
          dv_out    <= 1'b1;
          if (k == 5'd0) begin
            vad <= $signed(coef) > VAD_THRESH;
          end
          acc <= '0;
          n   <= '0;
          if (k == KLAST) begin
            state <= S_IDLE;
          end else begin
            k     <= k + 5'd1;
            state <= S_MAC;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfcc.sv
// Scoreboard bench for mfcc: reference autocorrelation model in plain
// arithmetic, monitor pops expectations on every dv_out pulse.
module tb_mfcc;

  logic        clk;
  logic        rst_n;
  logic [15:0] x_i;
  logic        write;
  logic [31:0] x_o;
  logic [4:0]  out_index;
  logic        dv_out;
  logic        vad;

  mfcc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (clk),
    .x_i       (x_i),
    .write     (write),
    .x_o       (x_o),
    .out_index (out_index),
    .dv_out    (dv_out),
    .vad       (vad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     idx;
    longint val;
    bit     vad;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;
  bit     model_vad = 0;
  longint last_val = 0;
  int     s[64];

  task automatic push_frame();
    for (int kk = 0; kk < 20; kk++) begin
      longint r = 0;
      exp_t e;
      for (int nn = 0; nn < 64 - kk; nn++)
        r += longint'(s[nn]) * longint'(s[nn + kk]);
      e.idx = kk;
      e.val = r >>> 6;
      if (kk == 0) model_vad = (e.val > 64'sd1000000);
      e.vad = model_vad;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dv_out) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dv idx=%0d x_o=%0d", out_index,
                 $signed(x_o));
      end else begin
        exp_t e;
        e = q.pop_front();
        last_val = e.val;
        if (longint'($signed(x_o)) != e.val || int'(out_index) != e.idx
            || vad != e.vad) begin
          errors++;
          $display("FAIL coef got idx=%0d x_o=%0d vad=%0b want idx=%0d x_o=%0d vad=%0b",
                   out_index, $signed(x_o), vad, e.idx, e.val, e.vad);
        end
      end
    end
  end

  task automatic put(input int v, input int gap);
    x_i   = 16'(v);
    write = 1'b1;
    @(posedge clk);
    #1 write = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic write_range(input int lo, input int hi, input int maxgap);
    for (int i = lo; i < hi; i++)
      put(s[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 64; i++) s[i] = v;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 2100) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s pending=%0d want 0 within 2100 cycles",
               name, q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint got,
                       input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    model_vad = 0;
    #3 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    write = 1'b0;
    x_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    write = 1'b1;
    @(posedge clk);
    #1;
    check("rst_x_o", longint'(x_o), 0);
    check("rst_idx", longint'(out_index), 0);
    check("rst_dv", longint'(dv_out), 0);
    check("rst_vad", longint'(vad), 0);
    write = 1'b0;
    rst_n = 1'b1;
    #1;

    fill_const(0);
    write_range(0, 64, 0);
    push_frame();
    wait_drain("zeros");
    check("zeros_vad", longint'(vad), 0);

    fill_const(256);
    write_range(0, 64, 0);
    push_frame();
    wait_drain("c256");
    check("c256_k19", longint'($signed(x_o)), 46080);
    check("c256_vad", longint'(vad), 0);

    fill_const(4096);
    write_range(0, 64, 1);
    push_frame();
    wait_drain("c4096");
    check("c4096_k19", longint'($signed(x_o)), 11796480);
    check("c4096_vad", longint'(vad), 1);
    repeat (7) @(posedge clk);
    #1;
    check("hold_x_o", longint'($signed(x_o)), last_val);
    check("hold_idx", longint'(out_index), 19);

    for (int i = 0; i < 64; i++) s[i] = (i % 2 == 0) ? 1000 : -1000;
    write_range(0, 64, 0);
    push_frame();
    wait_drain("alt");
    check("alt_vad", longint'(vad), 0);

    fill_const(777);
    write_range(0, 30, 0);
    do_reset();
    check("midframe_rst_vad", longint'(vad), 0);
    fill_const(256);
    write_range(0, 64, 0);
    push_frame();
    wait_drain("after_rst");

    fill_const(-3000);
    write_range(0, 64, 0);
    push_frame();
    repeat (300) @(posedge clk);
    #1;
    do_reset();
    check("midcomp_rst_x_o", longint'(x_o), 0);
    fill_const(4096);
    write_range(0, 64, 0);
    push_frame();
    wait_drain("after_comp_rst");

    fill_const(256);
    write_range(0, 64, 0);
    push_frame();
    fill_const(4096);
    write_range(0, 64, 0);
    wait_drain("frame_a");
    fill_const(4096);
    write_range(0, 64, 0);
    push_frame();
    wait_drain("after_drop");

    for (int f = 0; f < 3; f++) begin
      int m;
      for (int i = 0; i < 64; i++)
        s[i] = int'($urandom_range(0, 65535)) - 32768;
      write_range(0, 64, 2);
      push_frame();
      for (int i = 0; i < 64; i++)
        s[i] = int'($urandom_range(0, 4000)) - 2000;
      m = int'($urandom_range(1, 60));
      write_range(0, m, 1);
      wait_drain("rand_a");
      write_range(m, 64, 2);
      push_frame();
      wait_drain("rand_b");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
